and12_qualified_match: RTL and testbench

//   Qualified 12-bit match detector built around the AND12 schematic macro.

---
 rtl/and12_match_pkg.sv | 15 +
 rtl/and12_qualified_match_and12.sv | 11 +
 rtl/and12_qualified_match.sv | 119 +++++++++++
 tb/tb_and12_qualified_match.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/and12_match_pkg.sv
// Shared types for the qualified AND12 match detector: condition vector type
// and the debounce state encoding.
package and12_match_pkg;

    localparam int COND_W = 12;

    typedef logic [COND_W-1:0] cond12_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        MATCHED = 2'd2
    } match_state_e;

endpackage

// File: rtl/and12_qualified_match_and12.sv
// Wrapper for the AND12 schematic macro: a plain 12-input AND.
module and12_qualified_match_and12
    import and12_match_pkg::*;
(
    input  logic [COND_W-1:0] terms_i,
    output logic              z_o
);

    assign z_o = &terms_i;

endmodule

// File: rtl/and12_qualified_match.sv
// Qualified 12-bit match detector: registered conditions with per-bit mask and
// polarity feed AND12, then a debounce FSM requires RAW for HOLD_CYCLES edges.
module and12_qualified_match
    import and12_match_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              CK,
    input  logic              CD,
    input  logic              EN,
    input  logic [COND_W-1:0] A,
    input  logic [COND_W-1:0] MASK,
    input  logic [COND_W-1:0] POL,
    input  logic              CLR_STICKY,
    output logic              Z0,
    output logic              MATCH,
    output logic              MATCH_PULSE,
    output logic              STICKY
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (2 ** CNT_W)) begin : g_bad_hold
        $error("and12_qualified_match: HOLD_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    cond12_t          aQ, aD;
    cond12_t          terms;
    logic [CNT_W-1:0] cntQ, cntD;
    match_state_e     stateQ, stateD;
    logic             matchQ, matchD;
    logic             pulseQ, pulseD;
    logic             stickyQ, stickyD;
    logic             raw;

    // A masked bit is forced true; POL=1 inverts the required level.
    assign terms = MASK | (aQ ^ POL);

    and12_qualified_match_and12 u_and12 (
        .terms_i (terms),
        .z_o     (raw)
    );

    always_comb begin
        aD      = aQ;
        cntD    = cntQ;
        stateD  = stateQ;
        pulseD  = 1'b0;

        // The FSM judges RAW as it stood before this edge's capture of A.
        if (EN) begin
            aD = A;
            unique case (stateQ)
                IDLE: begin
                    if (raw) begin
                        cntD   = ONE_C;
                        stateD = (HOLD_C == ONE_C) ? MATCHED : QUAL;
                        pulseD = (HOLD_C == ONE_C);
                    end else begin
                        cntD = '0;
                    end
                end
                QUAL: begin
                    if (raw) begin
                        cntD = cntQ + ONE_C;
                        if (cntQ + ONE_C == HOLD_C) begin
                            stateD = MATCHED;
                            pulseD = 1'b1;
                        end
                    end else begin
                        cntD   = '0;
                        stateD = IDLE;
                    end
                end
                MATCHED: begin
                    if (raw) begin
                        cntD = HOLD_C;
                    end else begin
                        cntD   = '0;
                        stateD = IDLE;
                    end
                end
                default: begin
                    cntD   = '0;
                    stateD = IDLE;
                end
            endcase
        end

        matchD  = (stateD == MATCHED);
        stickyD = pulseD | (stickyQ & ~CLR_STICKY);
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            aQ      <= '0;
            cntQ    <= '0;
            stateQ  <= IDLE;
            matchQ  <= 1'b0;
            pulseQ  <= 1'b0;
            stickyQ <= 1'b0;
        end else begin
            aQ      <= aD;
            cntQ    <= cntD;
            stateQ  <= stateD;
            matchQ  <= matchD;
            pulseQ  <= pulseD;
            stickyQ <= stickyD;
        end
    end

    assign Z0          = raw;
    assign MATCH       = matchQ;
    assign MATCH_PULSE = pulseQ;
    assign STICKY      = stickyQ;

endmodule

// File: tb/tb_and12_qualified_match.sv
// Bench for and12_qualified_match: run-length reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_and12_qualified_match;

    localparam int HOLD = 4;

    logic        ck = 1'b0;
    logic        cd, en, clrSticky;
    logic [11:0] a, mask, pol;
    logic        z0, match, matchPulse, sticky;

    int checks = 0;
    int errors = 0;

    // Reference state: registered A and the length of the current run of qualified RAW=1 edges.
    logic [11:0] mA;
    int          runLen;
    logic        mMatch, mPulse, mSticky;

    and12_qualified_match #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (8)
    ) dut (
        .CK          (ck),
        .CD          (cd),
        .EN          (en),
        .A           (a),
        .MASK        (mask),
        .POL         (pol),
        .CLR_STICKY  (clrSticky),
        .Z0          (z0),
        .MATCH       (match),
        .MATCH_PULSE (matchPulse),
        .STICKY      (sticky)
    );

    always #5 ck = ~ck;

    function automatic logic modelRaw(input logic [11:0] aq, input logic [11:0] m, input logic [11:0] p);
        for (int i = 0; i < 12; i++) begin
            if (!m[i] && (aq[i] == p[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs at a falling edge and let them act on the next n rising edges.
    task automatic applyStimulus(input logic cdV, input logic enV, input logic [11:0] aV,
                                 input logic [11:0] maskV, input logic [11:0] polV,
                                 input logic clrV, input int n);
        cd = cdV; en = enV; a = aV; mask = maskV; pol = polV; clrSticky = clrV;
        repeat (n) @(negedge ck);
    endtask

    // Advance the model on each rising edge, then compare shortly after.
    always @(posedge ck) begin
        logic rawNow;
        logic newMatch;
        if (cd) begin
            mA = '0; runLen = 0; mMatch = 0; mPulse = 0; mSticky = 0;
        end else if (en) begin
            rawNow   = modelRaw(mA, mask, pol);
            runLen   = rawNow ? ((runLen < HOLD) ? runLen + 1 : HOLD) : 0;
            newMatch = (runLen >= HOLD);
            mPulse   = newMatch && !mMatch;
            mMatch   = newMatch;
            mA       = a;
            mSticky  = mPulse | (mSticky & ~clrSticky);
        end else begin
            mPulse  = 1'b0;
            mSticky = mSticky & ~clrSticky;
        end
        #1;
        checkOutput("cycle Z0", z0, modelRaw(mA, mask, pol));
        checkOutput("cycle MATCH", match, mMatch);
        checkOutput("cycle MATCH_PULSE", matchPulse, mPulse);
        checkOutput("cycle STICKY", sticky, mSticky);
    end

    initial begin
        // Reset with all-ones conditions pending
        applyStimulus(1, 1, 12'hFFF, 12'h000, 12'h000, 0, 2);
        checkOutput("reset MATCH", match, 1'b0);
        checkOutput("reset PULSE", matchPulse, 1'b0);
        checkOutput("reset STICKY", sticky, 1'b0);
        checkOutput("reset Z0", z0, 1'b0);

        // Basic match: Z0 one edge after release, MATCH four edges later
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 1);
        checkOutput("match Z0 e0", z0, 1'b1);
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 3);
        checkOutput("match MATCH e3", match, 1'b0);
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 1);
        checkOutput("match MATCH e4", match, 1'b1);
        checkOutput("match PULSE e4", matchPulse, 1'b1);
        checkOutput("match STICKY e4", sticky, 1'b1);
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 3);
        checkOutput("hold MATCH", match, 1'b1);
        checkOutput("hold PULSE", matchPulse, 1'b0);

        // Drop, then a 3-edge glitch that must not qualify
        applyStimulus(0, 1, 12'h000, 12'h000, 12'h000, 0, 2);
        checkOutput("drop MATCH", match, 1'b0);
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 3);
        applyStimulus(0, 1, 12'h7FF, 12'h000, 12'h000, 0, 3);
        checkOutput("glitch MATCH", match, 1'b0);
        checkOutput("glitch Z0", z0, 1'b0);
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 4);
        checkOutput("refresh MATCH e3", match, 1'b0);
        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 0, 1);
        checkOutput("refresh MATCH e4", match, 1'b1);
        checkOutput("refresh PULSE", matchPulse, 1'b1);

        applyStimulus(0, 1, 12'hFFF, 12'h000, 12'h000, 1, 1);
        checkOutput("clear STICKY", sticky, 1'b0);

        // Mask/polarity: bit 11 don't-care, bits 3..0 must be zero
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 0, 1);
        checkOutput("maskpol Z0", z0, 1'b1);
        checkOutput("maskpol MATCH drop", match, 1'b0);
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 0, 3);
        checkOutput("maskpol MATCH e3", match, 1'b0);
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 1, 1);
        checkOutput("maskpol MATCH e4", match, 1'b1);
        checkOutput("set-wins PULSE", matchPulse, 1'b1);
        checkOutput("set-wins STICKY", sticky, 1'b1);
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 1, 1);
        checkOutput("clr-alone STICKY", sticky, 1'b0);
        applyStimulus(0, 1, 12'h7F1, 12'h800, 12'h00F, 0, 1);
        checkOutput("bit0 Z0", z0, 1'b0);
        checkOutput("bit0 MATCH still", match, 1'b1);
        applyStimulus(0, 1, 12'h7F1, 12'h800, 12'h00F, 0, 1);
        checkOutput("bit0 MATCH drop", match, 1'b0);

        // Freeze with EN=0 at cnt=2, then resume
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 0, 3);
        applyStimulus(0, 0, 12'h000, 12'h800, 12'h00F, 0, 5);
        checkOutput("freeze MATCH", match, 1'b0);
        checkOutput("freeze Z0", z0, 1'b1);
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 0, 1);
        checkOutput("resume MATCH +1", match, 1'b0);
        applyStimulus(0, 1, 12'h7F0, 12'h800, 12'h00F, 0, 1);
        checkOutput("resume MATCH +2", match, 1'b1);
        checkOutput("resume PULSE", matchPulse, 1'b1);
        checkOutput("resume STICKY", sticky, 1'b1);

        // Reset while MATCHED
        applyStimulus(1, 1, 12'h7F0, 12'h800, 12'h00F, 0, 1);
        checkOutput("midreset MATCH", match, 1'b0);
        checkOutput("midreset PULSE", matchPulse, 1'b0);
        checkOutput("midreset STICKY", sticky, 1'b0);
        checkOutput("midreset Z0", z0, 1'b0);

        // Fully masked: RAW constant, MATCH HOLD edges after release
        applyStimulus(1, 1, 12'h000, 12'hFFF, 12'h000, 0, 1);
        checkOutput("allmask reset Z0", z0, 1'b1);
        applyStimulus(0, 1, 12'h000, 12'hFFF, 12'h000, 0, 3);
        checkOutput("allmask MATCH e3", match, 1'b0);
        applyStimulus(0, 1, 12'h000, 12'hFFF, 12'h000, 0, 1);
        checkOutput("allmask MATCH e4", match, 1'b1);
        applyStimulus(0, 1, 12'h000, 12'hFFF, 12'h000, 0, 3);
        checkOutput("allmask MATCH stays", match, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
